// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: turns a 512-bit big-endian AXIS message stream into padded blocks
// (0x80 marker, zero fill, 64-bit bit length), adding a trailing block when the pad does not fit.
module sha256_msg_padder #(
    parameter int C_AXIS_DATA_WIDTH  = 512,
    parameter int C_AXIS_TUSER_WIDTH = 128
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast
);

    typedef enum logic {
        ST_IDLE,
        ST_EXTRA
    } state_t;

    state_t        r_state;
    logic [60:0]   r_byte_cnt;
    logic [63:0]   r_extra_len;
    logic          r_extra_lead;

    logic [6:0]    w_n;
    logic          w_keep_run;
    logic [60:0]   w_total;
    logic [63:0]   w_len;
    logic [511:0]  w_last_block;
    logic [511:0]  w_block;
    logic          w_out_free;
    logic          w_accept;

    assign w_out_free    = ~m_axis_tvalid | m_axis_tready;
    assign s_axis_tready = ~reset & (r_state == ST_IDLE) & w_out_free;
    assign w_accept      = s_axis_tvalid & s_axis_tready;

    assign w_total = r_byte_cnt + 61'(w_n);
    assign w_len   = {w_total, 3'b000};

    // Valid byte count of the last beat: length of the leading run of ones in tkeep.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        w_n        = '0;
        w_keep_run = 1'b1;
        for (int k = 0; k < 64; k++) begin
            w_keep_run = w_keep_run & s_axis_tkeep[63-k];
            if (w_keep_run) w_n = 7'(k + 1);
        end
    end

    always_comb begin
        w_last_block = '0;
        for (int k = 0; k < 64; k++) begin
            if (7'(k) < w_n)
                w_last_block[511-8*k -: 8] = s_axis_tdata[511-8*k -: 8];
            else if (7'(k) == w_n)
                w_last_block[511-8*k -: 8] = 8'h80;
        end
        // The length only fits behind the marker when at most 55 data bytes remain.
        if (w_n <= 7'd55) w_last_block[63:0] = w_len;
        w_block = s_axis_tlast ? w_last_block : s_axis_tdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_byte_cnt    <= '0;
            r_extra_len   <= '0;
            r_extra_lead  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; a later load in this block overrides the clear.
            if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= w_block;
                        m_axis_tuser  <= s_axis_tuser;
                        if (s_axis_tlast) begin
                            r_byte_cnt   <= '0;
                            r_extra_len  <= w_len;
                            r_extra_lead <= (w_n == 7'd64);
                            if (w_n >= 7'd56) begin
                                m_axis_tlast <= 1'b0;
                                r_state      <= ST_EXTRA;
                            end else begin
                                m_axis_tlast <= 1'b1;
                            end
                        end else begin
                            m_axis_tlast <= 1'b0;
                            r_byte_cnt   <= r_byte_cnt + 61'd64;
                        end
                    end
                end
                ST_EXTRA: begin
                    // Block1 is still held in the output register; swap in block2 as it leaves.
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= {(r_extra_lead ? 8'h80 : 8'h00), 440'b0, r_extra_len};
                        m_axis_tlast  <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
